// File: rtl/fetch_pkg.sv
// Shared constants, queue entry type and address helper for the fetch front end.
package fetch_pkg;

  localparam int INST_BYTES = 4;
  localparam int PC_INC     = 4;
  localparam int IDX_W      = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

  // Byte address to word index; callers truncate to their memory width.
  function automatic logic [IDX_W-1:0] word_index(input logic [IDX_W-1:0] byte_addr);
    return byte_addr >> $clog2(INST_BYTES);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instruction} entries.
// Flush empties the queue and wins over any push or pop in the same cycle.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                         clk,
  input  logic                         clr_n,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Pointers wrap modulo DEPTH, so non-power-of-two depths work too.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) rd_ptr <= bump(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Stallable, redirectable instruction fetch front end with a small return queue.
// Define FETCH_BYPASS_EN to forward a return straight to decode when the queue is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                IMEM_AW  = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                QDEPTH   = 2
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [DATA_W-1:0]  imem_rdata,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [DATA_W-1:0]  inst_data,
  output logic [ADDR_W-1:0]  inst_pc
);

  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int ENT_W = ADDR_W + DATA_W;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] issued_pc;
  logic              inflight;
  logic              run;
  logic              issue;
  logic              pop;
  logic              qpush;
  logic              qpop;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  logic [ENT_W-1:0]  head_bits;
  entry_t            head;
  entry_t            ret;

  assign ret       = '{pc: issued_pc, data: imem_rdata};
  assign head      = head_bits;
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass     = inflight && !redirect_valid && (count == '0);
  assign inst_valid = bypass || (count != '0);
  assign inst_data  = bypass ? imem_rdata : head.data;
  assign inst_pc    = bypass ? issued_pc  : head.pc;
  assign qpush      = inflight && !redirect_valid && !(bypass && inst_ready);
  assign qpop       = pop && !bypass;
`else
  assign inst_valid = (count != '0);
  assign inst_data  = head.data;
  assign inst_pc    = head.pc;
  assign qpush      = inflight && !redirect_valid;
  assign qpop       = pop;
`endif

  // Counting the in-flight read as occupied guarantees every return has a slot.
  assign pop       = inst_valid && inst_ready;
  assign issue     = run && !redirect_valid && ((occupancy < (CNT_W+1)'(QDEPTH)) || pop);
  assign imem_en   = issue;
  assign imem_addr = IMEM_AW'(word_index(IDX_W'(pc)));

  // run holds off the first fetch until the cycle after reset is released.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pc        <= RESET_PC;
      issued_pc <= '0;
      inflight  <= 1'b0;
      run       <= 1'b0;
    end else begin
      run      <= 1'b1;
      inflight <= issue;
      if (redirect_valid) begin
        pc <= redirect_addr & ~ADDR_W'(INST_BYTES - 1);
      end else if (issue) begin
        pc        <= pc + ADDR_W'(PC_INC);
        issued_pc <= pc;
      end
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH),
    .W     (ENT_W)
  ) u_queue (
    .clk       (clk),
    .clr_n     (clr_n),
    .push      (qpush),
    .push_data (ret),
    .pop       (qpop),
    .flush     (redirect_valid),
    .head      (head_bits),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit plus a 12-bit PC wrap-around instance.
module tb_fetch_unit;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        imem_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  logic        redirect12 = 1'b0;
  logic [11:0] raddr12 = '0;
  logic        imem_en12;
  logic [9:0]  imem_addr12;
  logic [31:0] imem_rdata12 = '0;
  logic        inst_valid12;
  logic        ready12 = 1'b0;
  logic [31:0] inst_data12;
  logic [11:0] inst_pc12;

  int checks = 0;
  int failures = 0;
  int delivered104 = 0;

  typedef struct {
    logic        rst_n;
    logic        redir;
    logic [31:0] raddr;
    logic        ready;
    logic        en;
    logic [9:0]  addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_data[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .clr_n          (clr_n),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  fetch_unit #(.ADDR_W(12)) dut12 (
    .clk            (clk),
    .clr_n          (clr_n),
    .redirect_valid (redirect12),
    .redirect_addr  (raddr12),
    .imem_en        (imem_en12),
    .imem_addr      (imem_addr12),
    .imem_rdata     (imem_rdata12),
    .inst_valid     (inst_valid12),
    .inst_ready     (ready12),
    .inst_data      (inst_data12),
    .inst_pc        (inst_pc12)
  );

  // Instruction memory models: word k holds BASE + k, one cycle read latency.
  always @(posedge clk) begin
    if (imem_en)   imem_rdata   <= BASE + {22'b0, imem_addr};
    if (imem_en12) imem_rdata12 <= BASE + {22'b0, imem_addr12};
  end

  task automatic addVec(input logic r, input logic rd, input logic [31:0] ra, input logic rdy,
                        input logic en, input logic [9:0] a, input logic v,
                        input logic [31:0] p, input logic [31:0] d);
    vec_t t;
    t.rst_n = r; t.redir = rd; t.raddr = ra; t.ready = rdy;
    t.en = en; t.addr = a; t.valid = v; t.pc = p; t.data = d;
    vecs.push_back(t);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    clr_n          = v.rst_n;
    redirect_valid = v.redir;
    redirect_addr  = v.raddr;
    inst_ready     = v.ready;
    #1;
    checkOutput($sformatf("v%0d_imem_en", idx), {31'b0, imem_en}, {31'b0, v.en});
    if (v.en) checkOutput($sformatf("v%0d_imem_addr", idx), {22'b0, imem_addr}, {22'b0, v.addr});
    checkOutput($sformatf("v%0d_inst_valid", idx), {31'b0, inst_valid}, {31'b0, v.valid});
    if (v.valid || !v.rst_n) begin
      checkOutput($sformatf("v%0d_inst_pc", idx), inst_pc, v.pc);
      checkOutput($sformatf("v%0d_inst_data", idx), inst_data, v.data);
    end
    if (inst_valid && inst_ready && inst_pc == 32'h104) delivered104++;
  endtask

  initial begin
    // Columns: rst_n redir raddr ready | en addr valid pc data
`ifdef FETCH_BYPASS_EN
    addVec(0, 0, 0,         0,  0, 10'h000, 0, 32'h000, 32'h0);
    addVec(1, 0, 0,         1,  0, 10'h000, 0, 32'h000, 32'h0);
    addVec(1, 0, 0,         1,  1, 10'h000, 0, 32'h000, 32'h0);
    addVec(1, 0, 0,         1,  1, 10'h001, 1, 32'h000, BASE + 32'h00);
    addVec(1, 0, 0,         1,  1, 10'h002, 1, 32'h004, BASE + 32'h01);
    addVec(1, 1, 32'h101,   1,  0, 10'h000, 0, 32'h000, 32'h0);
    addVec(1, 0, 0,         1,  1, 10'h040, 0, 32'h000, 32'h0);
    addVec(1, 0, 0,         1,  1, 10'h041, 1, 32'h100, BASE + 32'h40);
    addVec(1, 0, 0,         0,  1, 10'h042, 1, 32'h104, BASE + 32'h41);
    addVec(1, 0, 0,         0,  0, 10'h000, 1, 32'h104, BASE + 32'h41);
    addVec(1, 0, 0,         1,  1, 10'h043, 1, 32'h104, BASE + 32'h41);
    addVec(1, 0, 0,         1,  1, 10'h044, 1, 32'h108, BASE + 32'h42);
    addVec(1, 0, 0,         1,  1, 10'h045, 1, 32'h10C, BASE + 32'h43);
`else
    addVec(0, 0, 0,         0,  0, 10'h000, 0, 32'h000, 32'h0);
    addVec(1, 0, 0,         1,  0, 10'h000, 0, 32'h000, 32'h0);
    addVec(1, 0, 0,         1,  1, 10'h000, 0, 32'h000, 32'h0);
    addVec(1, 0, 0,         1,  1, 10'h001, 0, 32'h000, 32'h0);
    addVec(1, 0, 0,         1,  1, 10'h002, 1, 32'h000, BASE + 32'h00);
    addVec(1, 0, 0,         1,  1, 10'h003, 1, 32'h004, BASE + 32'h01);
    addVec(1, 0, 0,         1,  1, 10'h004, 1, 32'h008, BASE + 32'h02);
    // Reset mid-operation, then backpressure from the first fetch.
    addVec(0, 0, 0,         0,  0, 10'h000, 0, 32'h000, 32'h0);
    addVec(1, 0, 0,         0,  0, 10'h000, 0, 32'h000, 32'h0);
    addVec(1, 0, 0,         0,  1, 10'h000, 0, 32'h000, 32'h0);
    addVec(1, 0, 0,         0,  1, 10'h001, 0, 32'h000, 32'h0);
    addVec(1, 0, 0,         0,  0, 10'h000, 1, 32'h000, BASE + 32'h00);
    addVec(1, 0, 0,         0,  0, 10'h000, 1, 32'h000, BASE + 32'h00);
    addVec(1, 0, 0,         0,  0, 10'h000, 1, 32'h000, BASE + 32'h00);
    addVec(1, 0, 0,         0,  0, 10'h000, 1, 32'h000, BASE + 32'h00);
    addVec(1, 0, 0,         1,  1, 10'h002, 1, 32'h000, BASE + 32'h00);
    addVec(1, 0, 0,         1,  1, 10'h003, 1, 32'h004, BASE + 32'h01);
    addVec(1, 0, 0,         1,  1, 10'h004, 1, 32'h008, BASE + 32'h02);
    // Misaligned redirect with one queued entry and a read in flight.
    addVec(1, 1, 32'h102,   0,  0, 10'h000, 1, 32'h00C, BASE + 32'h03);
    addVec(1, 0, 0,         1,  1, 10'h040, 0, 32'h000, 32'h0);
    addVec(1, 0, 0,         1,  1, 10'h041, 0, 32'h000, 32'h0);
    addVec(1, 0, 0,         1,  1, 10'h042, 1, 32'h100, BASE + 32'h40);
    // Redirect in the same cycle as a pop of pc 0x104.
    addVec(1, 1, 32'h200,   1,  0, 10'h000, 1, 32'h104, BASE + 32'h41);
    addVec(1, 0, 0,         1,  1, 10'h080, 0, 32'h000, 32'h0);
    addVec(1, 0, 0,         1,  1, 10'h081, 0, 32'h000, 32'h0);
    addVec(1, 0, 0,         1,  1, 10'h082, 1, 32'h200, BASE + 32'h80);
`endif

    $display("[TB] applying %0d vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);
    checkOutput("pc104_delivered_once", delivered104, 1);

    // 12-bit PC wrap-around on the second instance.
    @(negedge clk);
    redirect12 = 1'b1;
    raddr12    = 12'hFFC;
    ready12    = 1'b1;
    #1;
    checkOutput("wrap_redirect_no_issue", {31'b0, imem_en12}, 32'h0);
    @(negedge clk);
    redirect12 = 1'b0;
    #1;
    checkOutput("wrap_first_en", {31'b0, imem_en12}, 32'h1);
    checkOutput("wrap_first_addr", {22'b0, imem_addr12}, 32'h3FF);
    for (int c = 0; c < 12 && got_pc.size() < 3; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      if (inst_valid12 && ready12) begin
        got_pc.push_back({20'b0, inst_pc12});
        got_data.push_back(inst_data12);
      end
    end
    checkOutput("wrap_delivered_count", got_pc.size(), 3);
    if (got_pc.size() > 0) begin
      checkOutput("wrap_pc0", got_pc[0], 32'hFFC);
      checkOutput("wrap_data0", got_data[0], BASE + 32'h3FF);
    end
    if (got_pc.size() > 1) begin
      checkOutput("wrap_pc1", got_pc[1], 32'h000);
      checkOutput("wrap_data1", got_data[1], BASE);
    end
    if (got_pc.size() > 2) begin
      checkOutput("wrap_pc2", got_pc[2], 32'h004);
      checkOutput("wrap_data2", got_data[2], BASE + 32'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
